mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multicycle sequencer between the CPU control unit and the word-wide data memory. It executes byte, halfword and word loads and stores, and waits out a fixed memory latency. It performs read-modify-write for sub-word stores and returns a zero-extended load result. It replaces ad-hoc load/store states in the main control FSM with a single start/done handshake.

## Interface
Parameters:
- MEM_LAT, 1: cycles from `mem_addr` valid to `mem_dout` valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled when not busy.
- op  input  2  access size: 1 byte, 2 halfword, 3 word; 0 means no request.
- we  input  1  1 store, 0 load; latched with start.
- addr  input  32  byte address; latched with start.
- wdata  input  32  store data; the low byte/half is used for sub-word stores.
- mem_dout  input  32  memory read data.
- mem_addr  output  32  word address to memory, {addr[31:2],2'b00}; registered.
- mem_wr  output  1  memory write enable; registered, one cycle per store.
- mem_din  output  32  memory write data; registered.
- rdata  output  32  zero-extended load result; held until the next accepted load.
- busy  output  1  high in RD and WR states.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle misalignment pulse, in place of done; exists only with MEMCTRL_ALIGN_CHECK_EN.

## Operation
- States: IDLE, RD, WR, DONE.
- Acceptance:
  - A request is accepted in IDLE or DONE when start=1 and op!=0.
  - op=0 or start=0 means no request.
  - start during RD or WR is ignored; no queueing.
- On accept: latch op, we, addr and wdata; drive mem_addr. The next state is:
  - load → RD
  - word store → WR
  - sub-word store → RD
- RD:
  - Down-counter loaded with MEM_LAT-1; RD lasts exactly MEM_LAT cycles.
  - In the last RD cycle, mem_dout is captured into an internal buffer.
  - Load → DONE. Store → WR.
- Load extraction (little-endian, k = addr[1:0]):
  - byte: {24'b0, buf[8k+7:8k]}
  - halfword: {16'b0, buf[16h+15:16h]}, h = addr[1]
  - word: buf
  - rdata updates on the RD→DONE transition.
- WR:
  - mem_wr=1 for exactly one cycle.
  - word: mem_din = wdata.
  - byte: mem_din = buf with lane k replaced by wdata[7:0].
  - half: mem_din = buf with half h replaced by wdata[15:0].
  - WR always goes to DONE.
- DONE:
  - done=1 for one cycle.
  - Goes back to IDLE, unless a new request is accepted in the same cycle.
- Stores never modify rdata.
- The address wraps naturally; there is no special boundary handling.
- Reset:
  - Every output reads 0: mem_addr, mem_wr, mem_din, rdata, busy, done, err. The state is IDLE and the counter is 0.
  - Reset during RD aborts the access; no write is issued.
  - Reset during WR: the write registered for that cycle still reaches memory; mem_wr is 0 from the next cycle.

## Timing
- The start cycle is cycle 0.
- Load: RD in cycles 1..MEM_LAT; done in cycle MEM_LAT+1.
- Word store: mem_wr in cycle 1; done in cycle 2.
- Sub-word store: RD in cycles 1..MEM_LAT; mem_wr in cycle MEM_LAT+1; done in cycle MEM_LAT+2.
- Back-to-back: a start in a DONE cycle is accepted; the next access begins the following cycle with no IDLE bubble.
- busy falls in the same cycle done rises.

## Configuration
- MEMCTRL_ALIGN_CHECK_EN defined:
  - An accepted halfword with addr[0]=1, or word with addr[1:0]!=0, goes straight to DONE with no memory access.
  - In that DONE cycle, err=1 and done=0; rdata and memory are unchanged.
- Undefined:
  - No err port.
  - Halfword ignores addr[0]; word ignores addr[1:0]; every accepted request completes normally.

## Test plan
- Reset: hold reset=0 for 2 cycles mid-RD → all outputs 0, state IDLE, no mem_wr pulse afterwards.
- MEM_LAT=2, mem word 0xA1B2C3D4 at 0x100. Load byte from addr 0x102 → done in cycle 3, rdata=0x000000B2.
- Same word, load half from 0x102 → rdata=0x0000A1B2. Load word from 0x100 → rdata=0xA1B2C3D4.
- Store byte from 0x101, wdata=0x000000EE → one mem_wr in cycle 3, mem_din=0xA1B2EED4, mem_addr=0x100, done in cycle 4.
- Word store 0x12345678 to 0x200 with start re-asserted in the DONE cycle for a load from 0x200 → second done with rdata=0x12345678. Also: start pulsed while busy is ignored.
- With MEMCTRL_ALIGN_CHECK_EN, word load from 0x102 → err pulse in cycle 1, done=0, no mem access, rdata unchanged. Without the macro → rdata = word at 0x100.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the word-wide data memory: sub-word read-modify-write, zero-extended loads.
// Optional MEMCTRL_ALIGN_CHECK_EN: misaligned half/word requests finish with an err pulse instead of done.
//
// state | meaning
// IDLE  | waiting for a request
// RD    | waiting out MEM_LAT cycles of read latency
// WR    | one-cycle memory write
// DONE  | completion pulse; a new request may be accepted here
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_din,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done
`ifdef MEMCTRL_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic        we_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        accept;

  assign accept = ((state == IDLE) || (state == DONE)) && start && (op != 2'd0);

`ifdef MEMCTRL_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((op == 2'd2) && addr[0]) || ((op == 2'd3) && (addr[1:0] != 2'd0));
`endif

  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd1: begin
        case (lane)
          2'd0:    r = {24'b0, w[7:0]};
          2'd1:    r = {24'b0, w[15:8]};
          2'd2:    r = {24'b0, w[23:16]};
          default: r = {24'b0, w[31:24]};
        endcase
      end
      2'd2:    r = lane[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0] sz, input logic [1:0] lane,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd1: begin
        case (lane)
          2'd0:    r = {w[31:8], d[7:0]};
          2'd1:    r = {w[31:16], d[7:0], w[7:0]};
          2'd2:    r = {w[31:24], d[7:0], w[15:0]};
          default: r = {d[7:0], w[23:0]};
        endcase
      end
      2'd2:    r = lane[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_q     <= 2'd0;
      we_q     <= 1'b0;
      lane_q   <= 2'd0;
      wdata_q  <= 32'd0;
      mem_addr <= 32'd0;
      mem_wr   <= 1'b0;
      mem_din  <= 32'd0;
      rdata    <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MEMCTRL_ALIGN_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
`ifdef MEMCTRL_ALIGN_CHECK_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q    <= op;
            we_q    <= we;
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
`ifdef MEMCTRL_ALIGN_CHECK_EN
            if (misaligned) begin
              state <= DONE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else
`endif
            begin
              mem_addr <= {addr[31:2], 2'b00};
              busy     <= 1'b1;
              // Full-word stores need no read; sub-word stores read first to merge.
              if (we && (op == 2'd3)) begin
                state   <= WR;
                mem_wr  <= 1'b1;
                mem_din <= wdata;
              end else begin
                state <= RD;
                cnt   <= LAT_M1;
              end
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RD: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (we_q) begin
            state   <= WR;
            mem_wr  <= 1'b1;
            mem_din <= store_merge(op_q, lane_q, mem_dout, wdata_q);
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            rdata <= load_extract(op_q, lane_q, mem_dout);
          end
        end
        WR: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a word-array reference model of loads/stores.
// Define MEMCTRL_ALIGN_CHECK_EN for both files to exercise the misalignment error path.
module tb_mem_access_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] mem_dout;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_din;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err_s;

`ifdef MEMCTRL_ALIGN_CHECK_EN
  logic err;
  assign err_s = err;
`else
  assign err_s = 1'b0;
`endif

  mem_access_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we), .addr(addr),
    .wdata(wdata), .mem_dout(mem_dout), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_din(mem_din), .rdata(rdata), .busy(busy), .done(done)
`ifdef MEMCTRL_ALIGN_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Bench memory: 256 words aliased on addr[9:2], combinational read.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  assign mem_dout = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_din;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit poke);
    int idx;
    int k;
    int h;
    int cyc;
    int done_cyc;
    int wr_cyc;
    int wr_cnt;
    int exp_done;
    int exp_wr_cyc;
    bit mis;
    logic [31:0] word;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    idx = int'(a[9:2]);
    k = int'(a[1:0]);
    h = int'(a[1]);
    word = ref_mem[idx];
    exp_rd = last_rd;
    exp_word = word;
    mis = 1'b0;
`ifdef MEMCTRL_ALIGN_CHECK_EN
    mis = ((o == 2'd2) && a[0]) || ((o == 2'd3) && (a[1:0] != 2'd0));
`endif
    if (mis) begin
      exp_done = 1; exp_wr_cyc = 0;
    end else if (!w) begin
      exp_done = LAT + 1; exp_wr_cyc = 0;
      if (o == 2'd1)      exp_rd = (word >> (8 * k)) & 32'hff;
      else if (o == 2'd2) exp_rd = (word >> (16 * h)) & 32'hffff;
      else                exp_rd = word;
    end else if (o == 2'd3) begin
      exp_done = 2; exp_wr_cyc = 1; exp_word = d;
    end else begin
      exp_done = LAT + 2; exp_wr_cyc = LAT + 1;
      if (o == 2'd1)
        exp_word = (word & ~(32'hff << (8 * k))) | ((d & 32'hff) << (8 * k));
      else
        exp_word = (word & ~(32'hffff << (16 * h))) | ((d & 32'hffff) << (16 * h));
    end

    start = 1'b1; op = o; we = w; addr = a; wdata = d;
    tick();
    start = 1'b0; op = 2'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 1; done_cyc = 0; wr_cyc = 0; wr_cnt = 0;
    if (!mis) chk("busy_c1", 32'(busy), 32'd1);
    while (cyc < 40) begin
      if (mem_wr) begin
        wr_cnt++;
        wr_cyc = cyc;
        chk("mem_din", mem_din, exp_word);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      end
      if (done || err_s) begin
        done_cyc = cyc;
        break;
      end
      // A start while busy must be ignored.
      if (poke && busy) begin
        start = 1'b1;
        op = 2'($urandom_range(1, 3));
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("done_cyc", 32'(done_cyc), 32'(exp_done));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done_flag", 32'(done), 32'(!mis));
    chk("err_flag", 32'(err_s), 32'(mis));
    chk("wr_cnt", 32'(wr_cnt), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    chk("wr_cyc", 32'(wr_cyc), 32'(exp_wr_cyc));
    chk("rdata", rdata, exp_rd);
    last_rd = exp_rd;
    if (w && !mis) ref_mem[idx] = exp_word;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_din"}, mem_din, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err_s), 32'd0);
  endtask

  initial begin
    int stray;
    reset = 1'b0;
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_idx = 8'(i);
      pl_data = (i == 'h40) ? 32'hA1B2C3D4 : $urandom;
      ref_mem[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Directed cases around the word 0xA1B2C3D4 at 0x100.
    run_op(2'd1, 1'b0, 32'h102, 32'h0, 1'b0);
    chk("ld_byte_val", rdata, 32'h000000B2);
    run_op(2'd2, 1'b0, 32'h102, 32'h0, 1'b0);
    chk("ld_half_val", rdata, 32'h0000A1B2);
    run_op(2'd3, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("ld_word_val", rdata, 32'hA1B2C3D4);
    tick();
    run_op(2'd1, 1'b1, 32'h101, 32'h000000EE, 1'b0);
    tick();
    chk("st_byte_mem", mem[8'h40], 32'hA1B2EED4);
    run_op(2'd3, 1'b1, 32'h200, 32'h12345678, 1'b1);
    run_op(2'd3, 1'b0, 32'h200, 32'h0, 1'b1);
    chk("b2b_ld_val", rdata, 32'h12345678);
    run_op(2'd3, 1'b0, 32'h102, 32'h0, 1'b0);

    // Randomized traffic with occasional idle gaps and ignored starts.
    for (int n = 0; n < 80; n++) begin
      run_op(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      end
    end
    tick();

    // Reset during the read phase of a sub-word store aborts the write.
    start = 1'b1; op = 2'd1; we = 1'b1; addr = 32'h300; wdata = 32'h55;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst_rd");
    reset = 1'b1;
    last_rd = 32'd0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_wr || done) stray++;
    end
    chk("rst_rd_no_activity", 32'(stray), 32'd0);

    for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
